// File: rtl/alu_requester.sv
// alu_requester: issues commands into a backpressure-free ALU and returns
// results in issue order. A DEPTH-entry in-order buffer reserves an entry per
// issued op, so a result always has a place to land.
module alu_requester #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [2:0]                 cmd_aluop,
  input  logic [31:0]                cmd_a,
  input  logic [31:0]                cmd_b,
  output logic [2:0]                 aluop,
  output logic [31:0]                a,
  output logic [31:0]                b,
  output logic                       valid_i,
  input  logic [31:0]                f,
  input  logic                       valid_o,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [2:0]                 rsp_aluop,
  output logic [31:0]                rsp_a,
  output logic [31:0]                rsp_b,
  output logic [31:0]                rsp_f,
  output logic [$clog2(DEPTH):0]     inflight,
  output logic                       err
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  typedef struct packed {
    logic [2:0]  aluop;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] f;
  } entry_t;

  entry_t [DEPTH-1:0] ent_q, ent_d;
  logic [DEPTH-1:0]   done_q, done_d;
  logic [PW-1:0]      alloc_ptr_q, alloc_ptr_d;
  logic [PW-1:0]      res_ptr_q, res_ptr_d;
  logic [PW-1:0]      head_ptr_q, head_ptr_d;
  logic               err_q, err_d;
  logic               valid_i_q, valid_i_d;
  logic [2:0]         aluop_q, aluop_d;
  logic [31:0]        a_q, a_d;
  logic [31:0]        b_q, b_d;

  logic [PW-1:0] count;
  logic [AW-1:0] alloc_idx, res_idx, head_idx;
  logic          issue, capture, pop;

  // Occupancy and handshakes; cmd_ready looks only at registered pointers,
  // so a pop this cycle frees its slot for the next cycle, not this one.
  always_comb begin
    count     = alloc_ptr_q - head_ptr_q;
    inflight  = alloc_ptr_q - res_ptr_q;
    alloc_idx = alloc_ptr_q[AW-1:0];
    res_idx   = res_ptr_q[AW-1:0];
    head_idx  = head_ptr_q[AW-1:0];
    cmd_ready = !rst && (count < PW'(DEPTH));
    rsp_valid = done_q[head_idx] && (count != '0);
    issue     = cmd_valid && cmd_ready;
    capture   = valid_o && (inflight != '0);
    pop       = rsp_valid && rsp_ready;
    rsp_aluop = ent_q[head_idx].aluop;
    rsp_a     = ent_q[head_idx].a;
    rsp_b     = ent_q[head_idx].b;
    rsp_f     = ent_q[head_idx].f;
    aluop     = aluop_q;
    a         = a_q;
    b         = b_q;
    valid_i   = valid_i_q;
    err       = err_q;
  end

  // Next state: issue, capture and pop touch distinct entries, so their
  // updates can be applied in any order within the same cycle.
  always_comb begin
    ent_d       = ent_q;
    done_d      = done_q;
    alloc_ptr_d = alloc_ptr_q;
    res_ptr_d   = res_ptr_q;
    head_ptr_d  = head_ptr_q;
    err_d       = err_q;
    valid_i_d   = issue;
    aluop_d     = aluop_q;
    a_d         = a_q;
    b_d         = b_q;
    if (issue) begin
      ent_d[alloc_idx].aluop = cmd_aluop;
      ent_d[alloc_idx].a     = cmd_a;
      ent_d[alloc_idx].b     = cmd_b;
      ent_d[alloc_idx].f     = '0;
      done_d[alloc_idx]      = 1'b0;
      alloc_ptr_d            = alloc_ptr_q + PW'(1);
      aluop_d                = cmd_aluop;
      a_d                    = cmd_a;
      b_d                    = cmd_b;
    end
    if (capture) begin
      ent_d[res_idx].f = f;
      done_d[res_idx]  = 1'b1;
      res_ptr_d        = res_ptr_q + PW'(1);
    end else if (valid_o) begin
      // A result with nothing outstanding is dropped and flagged.
      err_d = 1'b1;
    end
    if (pop) begin
      done_d[head_idx] = 1'b0;
      head_ptr_d       = head_ptr_q + PW'(1);
    end
  end

  // State register; reset discards every entry at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent_q       <= '0;
      done_q      <= '0;
      alloc_ptr_q <= '0;
      res_ptr_q   <= '0;
      head_ptr_q  <= '0;
      err_q       <= 1'b0;
      valid_i_q   <= 1'b0;
      aluop_q     <= '0;
      a_q         <= '0;
      b_q         <= '0;
    end else begin
      ent_q       <= ent_d;
      done_q      <= done_d;
      alloc_ptr_q <= alloc_ptr_d;
      res_ptr_q   <= res_ptr_d;
      head_ptr_q  <= head_ptr_d;
      err_q       <= err_d;
      valid_i_q   <= valid_i_d;
      aluop_q     <= aluop_d;
      a_q         <= a_d;
      b_q         <= b_d;
    end
  end
endmodule

// File: doc/alu_requester.md
Name: alu_requester

Overview:
- Initiator-side companion to the alu block.
- Accepts operation commands over a valid/ready interface and drives aluop/a/b/valid_i into the ALU.
- Captures f on valid_o and returns results in issue order over a valid/ready response interface, paired with the original operands.
- Bounds outstanding work with an in-order tracking buffer, because the ALU has no backpressure.

Parameters:
- DEPTH, 4, max entries issued-but-not-yet-popped (in-flight plus completed-unread); power of 2, >=2.

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  command accepted when cmd_valid && cmd_ready at posedge
- cmd_aluop  input  3  operation code
- cmd_a  input  32  operand a
- cmd_b  input  32  operand b
- aluop  output  3  to ALU
- a  output  32  to ALU
- b  output  32  to ALU
- valid_i  output  1  to ALU, one-cycle pulse per issued op
- f  input  32  from ALU
- valid_o  input  1  from ALU, result strobe
- rsp_valid  output  1  result available at head
- rsp_ready  input  1  consumer accepts
- rsp_aluop  output  3  op of head entry
- rsp_a  output  32  a of head entry
- rsp_b  output  32  b of head entry
- rsp_f  output  32  result of head entry
- inflight  output  $clog2(DEPTH)+1  entries issued, result not yet received
- err  output  1  sticky protocol error

Behaviour:
- Reset values:
  - cmd_ready, valid_i, rsp_valid, err: 0
  - aluop, a, b: 0
  - inflight: 0
  - all pointers and done bits: 0
  - Reset asserted mid-operation discards all entries immediately.
- Buffer: DEPTH entries {aluop, a, b, f, done}, with three pointers, each $clog2(DEPTH)+1 bits with wrap bit:
  - alloc_ptr: next entry to issue into
  - res_ptr: oldest entry awaiting a result
  - head_ptr: oldest entry not yet popped
- count = alloc_ptr - head_ptr; inflight = alloc_ptr - res_ptr.
- cmd_ready = (count < DEPTH), computed from registered state only. A pop in the same cycle does not free space (no bypass).
- Issue: on cmd_valid && cmd_ready:
  - write operands into the entry at alloc_ptr, clear its done bit, increment alloc_ptr.
  - Next cycle: valid_i=1 and aluop/a/b equal the command fields.
  - Latency from command handshake to valid_i is exactly 1 cycle.
  - valid_i deasserts the following cycle unless another command was accepted; back-to-back commands give consecutive valid_i pulses.
  - a/b/aluop hold their last issued values when valid_i=0.
- Result capture, on valid_o:
  - If inflight>0: write f into the entry at res_ptr, set done, increment res_ptr.
  - If inflight==0: set err (sticky until rst); f is discarded, no state change.
  - Results are assumed to arrive in issue order; the ALU may return a result in the same cycle valid_i is high (zero-latency ALU). The entry is already allocated, so this is legal.
- Response:
  - rsp_valid = done[head_ptr] && count>0. rsp_* fields are combinational from the head entry.
  - On rsp_valid && rsp_ready: clear done, increment head_ptr.
  - rsp_* must hold stable while rsp_valid && !rsp_ready.
- Simultaneous events: issue, result capture and pop may all occur in one cycle, each on distinct entries.
  - Result capture never targets head when head is done.
  - Pointer wrap is handled by the extra MSB. Full is indicated by count==DEPTH; empty by count==0.
- Full: cmd_ready=0 until a pop; the ALU can always complete in-flight ops because their entries are reserved.

Test Plan:
- Single op: after reset release, cmd {aluop=3'b000, a=32'h0000_0005, b=32'h0000_0003}, ALU model returns f=32'h8 two cycles after valid_i -> valid_i high exactly 1 cycle after handshake with a=5, b=3; rsp_valid rises the cycle after valid_o with rsp_f=8, rsp_a=5, rsp_b=3; inflight goes 0->1->0.
- Fill/backpressure: DEPTH=4, rsp_ready=0, 6 commands offered back-to-back -> exactly 4 accepted; cmd_ready=0 once count=4; pop one -> cmd_ready returns 1 the next cycle, not the same cycle.
- Ordering/wrap: 10 ops a=i, b=i, rsp_ready toggling 1/0 each cycle, f=a+b -> responses in order with rsp_f=2*i; pointers wrap twice with no loss or duplication.
- Simultaneous: full buffer, same cycle pop of head, valid_o for an in-flight entry, and cmd_valid=1 -> pop and capture both succeed; command not accepted that cycle, accepted next.
- Protocol error: valid_o pulsed with inflight=0 -> err=1 the next cycle and stays 1; rsp_valid stays 0; err clears only on rst.
- Reset mid-operation: 3 entries outstanding, assert rst for 1 cycle -> all outputs 0 immediately (async); after release cmd_ready=1, inflight=0, rsp_valid=0.
